// File: rtl/decoded_block_uart_tx_pkg.sv
// Shared widths, packet constants and state encodings for the decoded-block UART streamer.
package decoded_block_uart_tx_pkg;

  localparam int TS_W    = 24;
  localparam int DATA_W  = 17;
  localparam int BLOCK_W = TS_W + DATA_W;
  localparam int PKT_LEN = 8;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } block_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_LATCH, ST_SEND} state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/decoded_block_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A new start is also taken in the done cycle so
// consecutive bytes go out with no idle bit between them.
module uart_tx_byte
  import decoded_block_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 96
) (
  input  logic       clk_96MHz,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        accept;

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d  = '0;
        accept = start;
      end
      TX_START: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = sh_q[0];
        state_d = TX_DATA;
      end
      TX_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        if (bit_q == 3'd7) begin
          tx_d    = 1'b1;
          state_d = TX_STOP;
        end else begin
          // sh_q[0] is always the bit on the wire; shift to expose the next one
          bit_d = bit_q + 3'd1;
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
        end
      end
      TX_STOP: if (cnt_q == BIT_LAST) begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = TX_IDLE;
        accept  = start;
      end
      default: state_d = TX_IDLE;
    endcase
    if (accept) begin
      state_d = TX_START;
      cnt_d   = '0;
      sh_d    = byte_in;
      tx_d    = 1'b0;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/decoded_block_uart_tx.sv
// Polls the block RAM count, fetches each new block by index and streams it as an
// 8-byte framed packet (sync, ts, data, xor checksum) on the UART pin.
module decoded_block_uart_tx
  import decoded_block_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = 96,
  parameter int         READY_TIMEOUT = 255,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
  input  logic               clk_96MHz,
  input  logic               reset,
  input  logic [7:0]         avl_blocks_nb,
  input  logic [BLOCK_W-1:0] block_wanted,
  input  logic               data_ready,
  output logic [7:0]         block_wanted_number,
  output logic               uart_tx,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TO_W = $clog2(READY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(READY_TIMEOUT - 1);
  localparam logic [2:0] BYTE_LAST = 3'(PKT_LEN - 1);

  state_e          state_q, state_d;
  logic [7:0]      next_idx_q, next_idx_d;
  logic [7:0]      bwn_q, bwn_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            to_q, to_d;
  block_t          shadow_q, shadow_d;
  logic [2:0]      byte_idx_q, byte_idx_d;

  logic                    tx_start, tx_done;
  logic [2:0]              send_idx;
  logic [7:0]              tx_byte, chk;
  logic [PKT_LEN-1:0][7:0] pkt;

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      next_idx_q <= '0;
      bwn_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
      shadow_q   <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      next_idx_q <= next_idx_d;
      bwn_q      <= bwn_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      to_q       <= to_d;
      shadow_q   <= shadow_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_idx_d = next_idx_q;
    bwn_d      = bwn_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    to_d       = 1'b0;
    shadow_d   = shadow_q;
    byte_idx_d = byte_idx_q;
    tx_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avl_blocks_nb < next_idx_q) begin
          next_idx_d = '0;
        end else if (avl_blocks_nb > next_idx_q) begin
          bwn_d   = next_idx_q;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cnt_d = cnt_q + 1'b1;
        // first FETCH cycle ignores data_ready: it may still belong to the previous index
        if (data_ready && cnt_q != '0) begin
          shadow_d = block_wanted;
          state_d  = ST_LATCH;
        end else if (cnt_q == TO_LAST) begin
          to_d       = 1'b1;
          next_idx_d = next_idx_q + 8'd1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_LATCH: begin
        next_idx_d = next_idx_q + 8'd1;
        byte_idx_d = '0;
        tx_start   = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: if (tx_done) begin
        if (byte_idx_q == BYTE_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
          tx_start   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt[0] = SYNC_BYTE;
    pkt[1] = shadow_q.ts[23:16];
    pkt[2] = shadow_q.ts[15:8];
    pkt[3] = shadow_q.ts[7:0];
    pkt[4] = {7'b0, shadow_q.data[16]};
    pkt[5] = shadow_q.data[15:8];
    pkt[6] = shadow_q.data[7:0];
    chk    = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4] ^ pkt[5] ^ pkt[6];
    pkt[7] = chk;
  end

  // byte 0 is launched from LATCH, the rest are chained on the previous byte's done
  assign send_idx = (state_q == ST_LATCH) ? 3'd0 : byte_idx_q + 3'd1;
  assign tx_byte  = pkt[send_idx];

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_96MHz(clk_96MHz),
    .reset    (reset),
    .start    (tx_start),
    .byte_in  (tx_byte),
    .tx       (uart_tx),
    .done     (tx_done)
  );

  assign block_wanted_number = bwn_q;
  assign busy                = busy_q;
  assign timeout_err         = to_q;

endmodule
